oh_pads_seq: RTL and testbench

Power-up and configuration sequencer for the sky130 pad ring. It waits for stable IO/core supplies and raises the pad high-voltage enable. It then loads a per-pad drive-mode word into each GPIO pad, one pad at a time, while the pads are held, and finally releases hold. Sits in the always-on core domain, between the chip reset/power-good logic and the oh_pads_* ring instances.

---
 rtl/oh_pads_seq.sv | 191 +++++++++++++++++++
 tb/tb_oh_pads_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/oh_pads_seq.sv
// Power-up and configuration sequencer for the sky130 pad ring.
// Sequence: wait for stable supplies, raise the pad enable, load each pad's drive mode, release hold.
module oh_pads_seq #(
    parameter int N    = 4,
    parameter int CFGW = 3,
    parameter int WAIT = 4,
    parameter int STEP = 2,
    parameter int CW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pwr_good,
    input  logic [N*CFGW-1:0] cfg_in,
    output logic              enable_h,
    output logic              hold_n,
    output logic [N*CFGW-1:0] pad_dm,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    // state     | meaning
    // S_IDLE    | after reset, waiting for start
    // S_WAIT_PWR| counting consecutive pwr_good cycles
    // S_ENABLE  | enable_h high, pads held, settling
    // S_LOAD    | writing one pad slice every STEP cycles
    // S_RELEASE | hold released, settling
    // S_DONE    | ring configured; start reconfigures
    // S_FAULT   | supply lost; sticky until start
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_PWR, S_ENABLE, S_LOAD, S_RELEASE, S_DONE, S_FAULT
    } state_t;

    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP - 1);
    localparam logic [CW-1:0] PAD_LAST  = CW'(N - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [N*CFGW-1:0]   snap_q, snap_d;
    logic [N*CFGW-1:0]   pad_q, pad_d;
    logic                en_q, en_d;
    logic                hn_q, hn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                load_en;
    logic [CW-1:0]       load_idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        pad_d    = pad_q;
        load_en  = 1'b0;
        load_idx = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_PWR;
                    cnt_d   = '0;
                    snap_d  = cfg_in;
                end
            end
            S_WAIT_PWR: begin
                if (!pwr_good) begin
                    cnt_d = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_ENABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ENABLE: begin
                if (!pwr_good) begin
                    state_d = S_FAULT;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d  = S_LOAD;
                    cnt_d    = '0;
                    idx_d    = '0;
                    load_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                if (!pwr_good) begin
                    state_d = S_FAULT;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == PAD_LAST) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d    = idx_q + CW'(1);
                        load_en  = 1'b1;
                        load_idx = idx_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE: begin
                if (!pwr_good) begin
                    state_d = S_FAULT;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (!pwr_good) begin
                    state_d = S_FAULT;
                end else if (start) begin
                    // Reconfigure: enable_h is already up, so go straight to LOAD
                    state_d = S_LOAD;
                    snap_d  = cfg_in;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load_en = 1'b1;
                end
            end
            S_FAULT: begin
                if (start) begin
                    state_d = S_WAIT_PWR;
                    cnt_d   = '0;
                    snap_d  = cfg_in;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < N; i++) begin
            if (load_en && load_idx == CW'(i)) begin
                pad_d[i*CFGW +: CFGW] = snap_d[i*CFGW +: CFGW];
            end
        end

        if (state_d == S_FAULT) begin
            pad_d = '0;
            cnt_d = '0;
            idx_d = '0;
        end

        en_d    = state_d inside {S_ENABLE, S_LOAD, S_RELEASE, S_DONE};
        hn_d    = state_d inside {S_RELEASE, S_DONE};
        busy_d  = state_d inside {S_WAIT_PWR, S_ENABLE, S_LOAD, S_RELEASE};
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            pad_q   <= '0;
            en_q    <= 1'b0;
            hn_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            pad_q   <= pad_d;
            en_q    <= en_d;
            hn_q    <= hn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign enable_h = en_q;
    assign hold_n   = hn_q;
    assign pad_dm   = pad_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_oh_pads_seq.sv
// Bench for oh_pads_seq: directed vector table, async-reset corner, then random stimulus
// checked every cycle against a phase/elapsed-time reference model.
module tb_oh_pads_seq;
    localparam int N    = 4;
    localparam int CFGW = 3;
    localparam int WAIT = 4;
    localparam int STEP = 2;
    localparam int CW   = 8;

    localparam int P_IDLE = 0, P_WAIT = 1, P_EN = 2, P_LOAD = 3, P_REL = 4, P_DONE = 5, P_FAULT = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              pwr_good;
    logic [N*CFGW-1:0] cfg_in;
    logic              enable_h, hold_n, busy, done, fault;
    logic [N*CFGW-1:0] pad_dm;

    int checks = 0;
    int errors = 0;

    oh_pads_seq #(.N(N), .CFGW(CFGW), .WAIT(WAIT), .STEP(STEP), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .pwr_good(pwr_good), .cfg_in(cfg_in),
        .enable_h(enable_h), .hold_n(hold_n), .pad_dm(pad_dm),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model: phase, cycles elapsed in phase, consecutive pwr_good run
    int            m_ph, m_el, m_run;
    logic [CFGW-1:0] m_pad  [N];
    logic [CFGW-1:0] m_snap [N];

    function automatic logic [16:0] outs();
        return {enable_h, hold_n, pad_dm, busy, done, fault};
    endfunction

    function automatic logic [16:0] model_exp();
        logic [N*CFGW-1:0] dm;
        logic en, hn, bz, dn, ft;
        for (int i = 0; i < N; i++) dm[i*CFGW +: CFGW] = m_pad[i];
        en = (m_ph == P_EN) || (m_ph == P_LOAD) || (m_ph == P_REL) || (m_ph == P_DONE);
        hn = (m_ph == P_REL) || (m_ph == P_DONE);
        bz = (m_ph == P_WAIT) || (m_ph == P_EN) || (m_ph == P_LOAD) || (m_ph == P_REL);
        dn = (m_ph == P_DONE);
        ft = (m_ph == P_FAULT);
        return {en, hn, dm, bz, dn, ft};
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_el = 0; m_run = 0;
        for (int i = 0; i < N; i++) begin m_pad[i] = '0; m_snap[i] = '0; end
    endtask

    task automatic take(input logic [N*CFGW-1:0] c);
        for (int i = 0; i < N; i++) m_snap[i] = c[i*CFGW +: CFGW];
    endtask

    task automatic go_fault();
        m_ph = P_FAULT;
        for (int i = 0; i < N; i++) m_pad[i] = '0;
    endtask

    task automatic model_edge(input logic s, input logic p, input logic [N*CFGW-1:0] c);
        case (m_ph)
            P_IDLE:  if (s) begin m_ph = P_WAIT; m_run = 0; take(c); end
            P_WAIT: begin
                if (p) begin
                    m_run++;
                    if (m_run == WAIT) begin m_ph = P_EN; m_el = 0; end
                end else m_run = 0;
            end
            P_EN: begin
                if (!p) go_fault();
                else begin
                    m_el++;
                    if (m_el == WAIT) begin m_ph = P_LOAD; m_el = 0; m_pad[0] = m_snap[0]; end
                end
            end
            P_LOAD: begin
                if (!p) go_fault();
                else begin
                    m_el++;
                    if (m_el == N*STEP) begin m_ph = P_REL; m_el = 0; end
                    else if (m_el % STEP == 0) m_pad[m_el/STEP] = m_snap[m_el/STEP];
                end
            end
            P_REL: begin
                if (!p) go_fault();
                else begin
                    m_el++;
                    if (m_el == WAIT) begin m_ph = P_DONE; m_el = 0; end
                end
            end
            P_DONE: begin
                if (!p) go_fault();
                else if (s) begin take(c); m_ph = P_LOAD; m_el = 0; m_pad[0] = m_snap[0]; end
            end
            P_FAULT: if (s) begin m_ph = P_WAIT; m_run = 0; take(c); end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (en,hn,dm,busy,done,fault)", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic [N*CFGW-1:0] c);
        @(negedge clk);
        start = s; pwr_good = p; cfg_in = c;
        @(posedge clk);
        model_edge(s, p, c);
        #1;
        check("model", outs(), model_exp());
    endtask

    typedef struct {
        logic        s;
        logic        p;
        logic [11:0] cfg;
        int          cyc;
        logic        en;
        logic        hn;
        logic [11:0] dm;
        logic        bz;
        logic        dn;
        logic        ft;
    } vec_t;

    function automatic vec_t mk(logic s, logic p, logic [11:0] cfg, int cyc,
                                logic en, logic hn, logic [11:0] dm, logic bz, logic dn, logic ft);
        vec_t v;
        v.s = s; v.p = p; v.cfg = cfg; v.cyc = cyc;
        v.en = en; v.hn = hn; v.dm = dm; v.bz = bz; v.dn = dn; v.ft = ft;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        // start held high throughout the busy phase and cfg_in changed after the snapshot
        vq.push_back(mk(1,1,12'hA53, 1, 0,0,12'h000,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 3, 0,0,12'h000,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 1, 1,0,12'h000,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 3, 1,0,12'h000,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 1, 1,0,12'h003,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 1, 1,0,12'h003,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 1, 1,0,12'h013,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 2, 1,0,12'h053,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 2, 1,0,12'hA53,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 1, 1,0,12'hA53,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 1, 1,1,12'hA53,1,0,0));
        vq.push_back(mk(1,1,12'hFFF, 3, 1,1,12'hA53,1,0,0));
        vq.push_back(mk(0,1,12'hFFF, 1, 1,1,12'hA53,0,1,0));
        vq.push_back(mk(0,1,12'hFFF, 2, 1,1,12'hA53,0,1,0));
        // reconfigure from DONE
        vq.push_back(mk(1,1,12'h111, 1, 1,0,12'hA51,1,0,0));
        vq.push_back(mk(0,1,12'h000, 4, 1,0,12'hB11,1,0,0));
        vq.push_back(mk(0,1,12'h000, 2, 1,0,12'h111,1,0,0));
        vq.push_back(mk(0,1,12'h000, 2, 1,1,12'h111,1,0,0));
        vq.push_back(mk(0,1,12'h000, 3, 1,1,12'h111,1,0,0));
        vq.push_back(mk(0,1,12'h000, 1, 1,1,12'h111,0,1,0));
        // start coincident with pwr_good drop in DONE
        vq.push_back(mk(1,0,12'h000, 1, 0,0,12'h000,0,0,1));
        vq.push_back(mk(0,0,12'h000, 2, 0,0,12'h000,0,0,1));
        vq.push_back(mk(1,0,12'h0C7, 1, 0,0,12'h000,1,0,0));
        vq.push_back(mk(0,0,12'h000, 3, 0,0,12'h000,1,0,0));
        // pwr_good 1,1,0,1,1,1,1
        vq.push_back(mk(0,1,12'h000, 2, 0,0,12'h000,1,0,0));
        vq.push_back(mk(0,0,12'h000, 1, 0,0,12'h000,1,0,0));
        vq.push_back(mk(0,1,12'h000, 3, 0,0,12'h000,1,0,0));
        vq.push_back(mk(0,1,12'h000, 1, 1,0,12'h000,1,0,0));
        vq.push_back(mk(0,1,12'h000, 4, 1,0,12'h007,1,0,0));
        vq.push_back(mk(0,1,12'h000, 3, 1,0,12'h007,1,0,0));
        vq.push_back(mk(0,1,12'h000, 1, 1,0,12'h0C7,1,0,0));
        // drop during LOAD at pad 2, then recover
        vq.push_back(mk(0,0,12'h000, 1, 0,0,12'h000,0,0,1));
        vq.push_back(mk(1,1,12'h5A5, 1, 0,0,12'h000,1,0,0));
        vq.push_back(mk(0,1,12'h000,19, 1,1,12'h5A5,1,0,0));
        vq.push_back(mk(0,1,12'h000, 1, 1,1,12'h5A5,0,1,0));

        reset = 1'b1; start = 1'b1; pwr_good = 1'b1; cfg_in = 12'hFFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 17'h0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            for (int k = 0; k < vq[i].cyc; k++) step(vq[i].s, vq[i].p, vq[i].cfg);
            check($sformatf("vec%0d", i), outs(),
                  {vq[i].en, vq[i].hn, vq[i].dm, vq[i].bz, vq[i].dn, vq[i].ft});
        end

        // async reset in the middle of RELEASE
        step(1, 1, 12'h03C);
        repeat (9) step(0, 1, 12'h000);
        check("in_release", outs(), {1'b1, 1'b1, 12'h03C, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", outs(), 17'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 12'h000);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 29) != 0,
                 12'($urandom_range(0, 4095)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
